latency_mem_slave: RTL and testbench
====================================

LATENCY_MEM_SLAVE -- requirements
Module: latency_mem_slave

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning wait cycles between request capture and ack; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning word-address width; array depth 2^ADDR_W 32-bit words.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port cpu_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cs  input  1  request valid from initiator (cache), held until ack.
REQ-006 SHALL have port writeMemoryEnable  input  1  1 = write request, 0 = read request; valid while cs=1.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[ADDR_W+1:2].
REQ-008 SHALL have port data  input  32  write data; valid while cs=1 and writeMemoryEnable=1.
REQ-009 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port memoryData  output  32  read data, valid when ack=1 for a read.
REQ-011 SHALL have port busy  output  1  high in BUSY or ACK state.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-013 IDLE: on cs=1, SHALL capture addr word index, data, writeMemoryEnable into request registers, load wait counter with LATENCY-1, go to BUSY; cs=0 stays IDLE.
REQ-014 BUSY: SHALL decrement counter each cycle; at counter=0 with cs=1 go to ACK.
REQ-015 BUSY: if cs=0 in any cycle, SHALL abort: go to IDLE, no write, no ack.
REQ-016 ACK: SHALL assert ack=1 for exactly this one cycle, then go to IDLE unconditionally.
REQ-017 Latency: cs first sampled high at edge N -> ack high during cycle following edge N+LATENCY (ack visible LATENCY+1 cycles after cs rises, REQ-001 count).
REQ-018 Read: on entering ACK, memoryData SHALL equal array[captured index]; memoryData SHALL hold that value until the next read ack.
REQ-019 Write: array[captured index] SHALL be updated with captured data at the edge entering ACK; memoryData unchanged by writes.
REQ-020 Request registers SHALL be used for the access; addr/data/writeMemoryEnable changes after capture SHALL be ignored.
REQ-021 If cs=1 in IDLE the cycle after ACK, SHALL treat it as a new request (back-to-back, one idle cycle between acks minimum).
REQ-022 addr[1:0] and addr[31:ADDR_W+2] SHALL be ignored (aligned, wrapping access; no error).
REQ-023 Read-after-write to same word SHALL return the newly written value.
REQ-024 ack SHALL never be asserted while state is IDLE or BUSY.

Reset
REQ-025 cpu_rst=1 at an edge SHALL force state IDLE, ack=0, busy=0, memoryData=0, counter=0, request registers=0.
REQ-026 Reset mid-BUSY SHALL abort the request with no write committed and no ack.
REQ-027 Reset SHALL NOT clear array contents; array initialised to all zero at time zero.
REQ-028 cpu_rst SHALL take priority over cs in the same cycle.

Verification
REQ-029 Reset then read addr=0x0000_0010, LATENCY=4 -> ack one cycle, 5 cycles after cs rise, memoryData=0x0000_0000.
REQ-030 Write addr=0x0000_0040 data=0xDEAD_BEEF, then read addr=0x0000_0043 -> second ack memoryData=0xDEAD_BEEF (offset bits ignored).
REQ-031 Write 0x1234_5678 to 0x0000_0004, drop cs after 2 BUSY cycles, then read 0x0000_0004 -> no ack on aborted write, read returns 0x0000_0000.
REQ-032 Back-to-back reads 0x8, 0xC with cs held high, addr switched in ack cycle -> two acks 5 cycles apart (LATENCY=4), each with correct word.
REQ-033 Write 0xCAFE_F00D to 0x100, assert cpu_rst during following read's BUSY, release, read 0x100 -> no ack before reset, post-reset read returns 0xCAFE_F00D, memoryData=0 right after reset.
REQ-034 addr=0x0000_1004 with ADDR_W=10 -> aliases word 1 (addr 0x4): write via one, read via other returns same value.

Source files
------------

// File: rtl/latency_mem_slave.sv
// Word-addressed memory slave with a fixed request-to-ack latency.
// A request is captured on cs, counted down in BUSY, then completed with a one-cycle ack.
module latency_mem_slave #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic        clock,
  input  logic        cpu_rst,
  input  logic        cs,
  input  logic        writeMemoryEnable,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        ack,
  output logic [31:0] memoryData,
  output logic        busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] req_idx_reg;
  logic [31:0]       req_data_reg;
  logic              req_we_reg;
  logic [31:0]       rd_data_reg;

  // Contents start at zero and survive reset; only the access path is reset.
  logic [31:0] mem_array [DEPTH] = '{default: 32'h0};

  logic capture;
  logic count_done;
  logic unused_addr_bits;

  assign capture    = (state_reg == ST_IDLE) && cs;
  // Last BUSY cycle with the initiator still holding the request.
  assign count_done = (state_reg == ST_BUSY) && cs && (cnt_reg == 4'd0);

  // Byte offset and bits above the array are simply dropped (aliasing access).
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  // State register
  always_ff @(posedge clock) begin
    if (cpu_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cs) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!cs) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ack  = 1'b0;
    busy = 1'b0;
    case (state_reg)
      ST_BUSY: begin
        busy = 1'b1;
      end
      ST_ACK: begin
        ack  = 1'b1;
        busy = 1'b1;
      end
      default: begin
        ack  = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  // Wait counter and request capture
  always_ff @(posedge clock) begin
    if (cpu_rst) begin
      cnt_reg      <= 4'd0;
      req_idx_reg  <= '0;
      req_data_reg <= 32'h0;
      req_we_reg   <= 1'b0;
    end else if (capture) begin
      cnt_reg      <= CNT_LOAD;
      req_idx_reg  <= addr[ADDR_W+1:2];
      req_data_reg <= data;
      req_we_reg   <= writeMemoryEnable;
    end else if ((state_reg == ST_BUSY) && cs && (cnt_reg != 4'd0)) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Array write port; reset on the committing edge cancels the write.
  always_ff @(posedge clock) begin
    if (!cpu_rst && count_done && req_we_reg) begin
      mem_array[req_idx_reg] <= req_data_reg;
    end
  end

  // Registered read, held until the next read completes.
  always_ff @(posedge clock) begin
    if (cpu_rst) begin
      rd_data_reg <= 32'h0;
    end else if (count_done && !req_we_reg) begin
      rd_data_reg <= mem_array[req_idx_reg];
    end
  end

  assign memoryData = rd_data_reg;

endmodule

// File: tb/tb_latency_mem_slave.sv
// Directed bench for latency_mem_slave: latency, read/write, abort, back-to-back,
// reset during a request and address aliasing.
module tb_latency_mem_slave;

  logic        clock = 1'b0;
  logic        cpu_rst;
  logic        cs;
  logic        writeMemoryEnable;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ack;
  logic [31:0] memoryData;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  latency_mem_slave #(.LATENCY(4), .ADDR_W(10)) dut (
    .clock             (clock),
    .cpu_rst           (cpu_rst),
    .cs                (cs),
    .writeMemoryEnable (writeMemoryEnable),
    .addr              (addr),
    .data              (data),
    .ack               (ack),
    .memoryData        (memoryData),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Issue one request, wait (bounded) for ack, drop cs and return to IDLE.
  task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int cyc, output logic [31:0] rd,
                         output logic bsy_ack, output logic ack_after);
    writeMemoryEnable = we;
    addr = a;
    data = d;
    cs   = 1'b1;
    cyc  = -1;
    rd   = 32'h0;
    bsy_ack = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack) begin
        cyc     = i;
        rd      = memoryData;
        bsy_ack = busy;
        break;
      end
    end
    cs = 1'b0;
    tick();
    ack_after = ack;
    $display("[TB] %s addr=%h data=%h ack_cycle=%0d rdata=%h",
             we ? "write" : "read ", a, d, cyc, rd);
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    cs = 1'b1;
    tick();
    tick();
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ack: got %b expected 0", ack);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (memoryData !== 32'h0) begin
      tests_failed++; $display("FAIL reset_memdata: got %h expected 00000000", memoryData);
    end
    cpu_rst = 1'b0;
    cs = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_read_latency();
    int cyc; logic [31:0] rd; logic b; logic aa;
    run_req(1'b0, 32'h0000_0010, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (cyc !== 5) begin
      tests_failed++; $display("FAIL read_latency: got %0d expected 5", cyc);
    end
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL read_zero: got %h expected 00000000", rd);
    end
    tests_run++;
    if (b !== 1'b1) begin
      tests_failed++; $display("FAIL busy_in_ack: got %b expected 1", b);
    end
    tests_run++;
    if (aa !== 1'b0) begin
      tests_failed++; $display("FAIL ack_one_cycle: got %b expected 0", aa);
    end
  endtask

  task automatic test_write_read_offset();
    int cyc; logic [31:0] rd; logic b; logic aa;
    run_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, cyc, rd, b, aa);
    tests_run++;
    if (cyc !== 5) begin
      tests_failed++; $display("FAIL write_latency: got %0d expected 5", cyc);
    end
    run_req(1'b0, 32'h0000_0043, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (rd !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL raw_offset: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_abort();
    int cyc; logic [31:0] rd; logic b; logic aa; logic seen;
    seen = 1'b0;
    writeMemoryEnable = 1'b1;
    addr = 32'h0000_0004;
    data = 32'h1234_5678;
    cs = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL busy_after_capture: got %b expected 1", busy);
    end
    seen |= ack;
    tick(); seen |= ack;
    tick(); seen |= ack;
    cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); seen |= ack;
    end
    $display("[TB] write addr=00000004 data=12345678 aborted ack_seen=%b", seen);
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL abort_no_ack: got %b expected 0", seen);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL abort_idle: got %b expected 0", busy);
    end
    run_req(1'b0, 32'h0000_0004, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL abort_no_write: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] rd; logic b; logic aa;
    int a1; int a2; logic [31:0] d1; logic [31:0] d2;
    run_req(1'b1, 32'h0000_0008, 32'h1111_1111, cyc, rd, b, aa);
    run_req(1'b1, 32'h0000_000C, 32'h2222_2222, cyc, rd, b, aa);
    a1 = -1; a2 = -1; d1 = 32'h0; d2 = 32'h0;
    writeMemoryEnable = 1'b0;
    addr = 32'h0000_0008;
    cs = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack) begin
        if (a1 < 0) begin
          a1 = i; d1 = memoryData; addr = 32'h0000_000C;
        end else begin
          a2 = i; d2 = memoryData; break;
        end
      end
    end
    cs = 1'b0;
    tick();
    $display("[TB] b2b reads ack1=%0d data=%h ack2=%0d data=%h", a1, d1, a2, d2);
    tests_run++;
    if (a1 !== 5) begin
      tests_failed++; $display("FAIL b2b_first_ack: got %0d expected 5", a1);
    end
    // IDLE cycle plus four BUSY cycles separate the two acks.
    tests_run++;
    if (a2 !== 11) begin
      tests_failed++; $display("FAIL b2b_second_ack: got %0d expected 11", a2);
    end
    tests_run++;
    if (d1 !== 32'h1111_1111) begin
      tests_failed++; $display("FAIL b2b_data1: got %h expected 11111111", d1);
    end
    tests_run++;
    if (d2 !== 32'h2222_2222) begin
      tests_failed++; $display("FAIL b2b_data2: got %h expected 22222222", d2);
    end
  endtask

  task automatic test_reset_abort();
    int cyc; logic [31:0] rd; logic b; logic aa; logic seen;
    run_req(1'b1, 32'h0000_0100, 32'hCAFE_F00D, cyc, rd, b, aa);
    tests_run++;
    if (memoryData !== 32'h2222_2222) begin
      tests_failed++; $display("FAIL write_keeps_memdata: got %h expected 22222222", memoryData);
    end
    seen = 1'b0;
    writeMemoryEnable = 1'b0;
    addr = 32'h0000_0100;
    cs = 1'b1;
    tick(); seen |= ack;
    tick(); seen |= ack;
    cpu_rst = 1'b1;
    tick(); seen |= ack;
    $display("[TB] read  addr=00000100 reset mid-busy ack_seen=%b rdata=%h", seen, memoryData);
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL rst_read_no_ack: got %b expected 0", seen);
    end
    tests_run++;
    if (memoryData !== 32'h0) begin
      tests_failed++; $display("FAIL rst_memdata: got %h expected 00000000", memoryData);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy);
    end
    cpu_rst = 1'b0;
    cs = 1'b0;
    tick();
    // Reset lands on the edge that would commit the write.
    seen = 1'b0;
    writeMemoryEnable = 1'b1;
    data = 32'hBAD0_BAD0;
    cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); seen |= ack;
    end
    cpu_rst = 1'b1;
    tick(); seen |= ack;
    cpu_rst = 1'b0;
    cs = 1'b0;
    tick(); seen |= ack;
    $display("[TB] write addr=00000100 data=bad0bad0 reset at commit ack_seen=%b", seen);
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL rst_write_no_ack: got %b expected 0", seen);
    end
    run_req(1'b0, 32'h0000_0100, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (rd !== 32'hCAFE_F00D) begin
      tests_failed++; $display("FAIL rst_keeps_array: got %h expected cafef00d", rd);
    end
    tests_run++;
    if (cyc !== 5) begin
      tests_failed++; $display("FAIL post_rst_latency: got %0d expected 5", cyc);
    end
  endtask

  task automatic test_capture();
    int cyc; logic [31:0] rd; logic b; logic aa;
    cyc = -1;
    writeMemoryEnable = 1'b1;
    addr = 32'h0000_0200;
    data = 32'h0000_0055;
    cs = 1'b1;
    tick();
    if (ack) cyc = 1;
    addr = 32'h0000_0204;
    data = 32'h0000_0099;
    writeMemoryEnable = 1'b0;
    for (int i = 2; i <= 20 && cyc < 0; i++) begin
      tick();
      if (ack) cyc = i;
    end
    cs = 1'b0;
    tick();
    $display("[TB] write addr=00000200 data=00000055 inputs changed ack_cycle=%0d", cyc);
    tests_run++;
    if (cyc !== 5) begin
      tests_failed++; $display("FAIL capture_latency: got %0d expected 5", cyc);
    end
    tests_run++;
    if (memoryData !== 32'hCAFE_F00D) begin
      tests_failed++; $display("FAIL capture_kept_write: got %h expected cafef00d", memoryData);
    end
    run_req(1'b0, 32'h0000_0200, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (rd !== 32'h0000_0055) begin
      tests_failed++; $display("FAIL capture_data: got %h expected 00000055", rd);
    end
    run_req(1'b0, 32'h0000_0204, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL capture_addr: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_alias();
    int cyc; logic [31:0] rd; logic b; logic aa;
    run_req(1'b1, 32'h0000_1004, 32'hA5A5_5A5A, cyc, rd, b, aa);
    run_req(1'b0, 32'h0000_0004, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (rd !== 32'hA5A5_5A5A) begin
      tests_failed++; $display("FAIL alias_high: got %h expected a5a55a5a", rd);
    end
    run_req(1'b1, 32'h0000_0004, 32'h0F0F_0F0F, cyc, rd, b, aa);
    run_req(1'b0, 32'hFFFF_F007, 32'h0, cyc, rd, b, aa);
    tests_run++;
    if (rd !== 32'h0F0F_0F0F) begin
      tests_failed++; $display("FAIL alias_wrap: got %h expected 0f0f0f0f", rd);
    end
  endtask

  initial begin
    cpu_rst = 1'b1;
    cs = 1'b0;
    writeMemoryEnable = 1'b0;
    addr = 32'h0;
    data = 32'h0;
    @(negedge clock);
    test_reset();
    test_read_latency();
    test_write_read_offset();
    test_abort();
    test_back_to_back();
    test_reset_abort();
    test_capture();
    test_alias();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
